ht_controller: RTL and testbench
================================

// Module: ht_controller
// PURPOSE
//  Sequential command controller for the small associative key/value table (lookup + hit path).
//  Owns the entry storage (key, value, valid bit per entry) and serialises LOOKUP/INSERT/DELETE/CLEAR
//  commands from one requester via valid/ready handshakes. Runs a round-robin eviction policy when full.
//  Sits between a client (CPU-side stub or testbench) and the table datapath.
// PARAMETERS
//  N_ENTRIES  4  number of table entries (>=2, power of 2)
//  KEY_W      3  key width in bits
//  VAL_W      3  value width in bits
// PORTS
//  clk        in   1                    clock, rising edge
//  rst_n      in   1                    asynchronous, active-low reset
//  req_valid  in   1                    request present
//  req_ready  out  1                    controller can accept a request (=1 only in IDLE)
//  req_op     in   2                    00 LOOKUP, 01 INSERT, 10 DELETE, 11 CLEAR
//  req_key    in   KEY_W                request key
//  req_value  in   VAL_W                value for INSERT (ignored otherwise)
//  rsp_valid  out  1                    response present
//  rsp_ready  in   1                    client accepts response
//  rsp_hit    out  1                    key matched a valid entry
//  rsp_value  out  VAL_W                LOOKUP: value; INSERT: old/evicted value; DELETE: removed value; else 0
//  rsp_evict  out  1                    INSERT displaced a valid entry with a different key
//  occupancy  out  $clog2(N_ENTRIES+1)  number of valid entries
// BEHAVIOUR
//  Reset (rst_n=0, async): all valid bits 0, rr_ptr=0, state IDLE, rsp_valid/rsp_hit/rsp_evict=0,
//   rsp_value=0, occupancy=0; req_ready=1 once released. Reset mid-command aborts it; no response issued.
//  FSM: IDLE -> MATCH -> UPDATE -> RESP -> IDLE.
//   IDLE:   req_ready=1; on req_valid&req_ready latch op/key/value (cycle T).
//   MATCH:  (T+1) compare latched key against every valid entry; hit_idx = lowest matching index;
//           free_idx = lowest invalid index; full = all valid.
//   UPDATE: (T+2) perform table write per op (below); register rsp_* fields.
//   RESP:   rsp_valid=1 from T+3; rsp_* held stable until rsp_valid&rsp_ready; then IDLE next cycle.
//  Minimum request-to-request spacing 4 cycles; req_* inputs ignored outside IDLE.
//  LOOKUP: hit -> rsp_hit=1, rsp_value=stored value; miss -> rsp_hit=0, rsp_value=0. Table unchanged.
//  INSERT: hit -> overwrite value at hit_idx, rsp_hit=1, rsp_value=old value, occupancy unchanged.
//          miss & !full -> write key/value at free_idx, set valid, occupancy+1, rsp_hit=0, rsp_value=0.
//          miss & full -> overwrite entry rr_ptr, rsp_evict=1, rsp_value=evicted value,
//          rr_ptr=(rr_ptr+1) mod N_ENTRIES. rr_ptr changes only on eviction.
//  DELETE: hit -> clear valid at hit_idx, occupancy-1, rsp_hit=1, rsp_value=removed value;
//          miss -> no change, rsp_hit=0, rsp_value=0.
//  CLEAR:  all valid=0, rr_ptr=0, occupancy=0; rsp_hit=0, rsp_value=0, rsp_evict=0.
//  Duplicate keys never coexist (INSERT checks hit first). rsp_evict=0 for all ops except evicting INSERT.
//  Key/value storage not reset; only valid bits matter. occupancy never exceeds N_ENTRIES, never underflows.
// TESTING
//  1 After reset INSERT (5,1),(6,2),(1,1),(2,3) -> each rsp_hit=0 rsp_evict=0; occupancy 1..4; rsp at T+3.
//  2 LOOKUP 6 -> rsp_hit=1 rsp_value=2; LOOKUP 2 -> hit, 3; LOOKUP 7 -> rsp_hit=0 rsp_value=0.
//  3 Full table, INSERT (4,7) -> rsp_evict=1 rsp_value=1 (key 5, entry 0), rr_ptr=1; LOOKUP 5 -> miss;
//    INSERT (3,5) -> evicts key 6, rsp_value=2; INSERT (2,6) -> rsp_hit=1 rsp_value=3, no evict.
//  4 DELETE 1 -> rsp_hit=1 rsp_value=1, occupancy 3; DELETE 1 again -> miss; INSERT (0,4) -> fills freed
//    entry, rsp_evict=0, occupancy 4; CLEAR -> occupancy 0, LOOKUP 4 misses.
//  5 Hold rsp_ready=0 for 5 cycles on a LOOKUP -> rsp_valid and rsp_* stable, req_ready=0; release -> IDLE.
//  6 Pull rst_n low during MATCH of an INSERT -> rsp_valid=0 immediately, occupancy=0, no response after
//    release; LOOKUP of previously inserted key misses.

Source files
------------

// File: rtl/ht_controller.sv
// Serialised LOOKUP/INSERT/DELETE/CLEAR controller over a small key/value table with round-robin eviction.
// A response appears 3 cycles after the request is accepted and is held until rsp_ready; req_ready is high only in IDLE.
module ht_controller #(
  parameter int N_ENTRIES = 4,
  parameter int KEY_W     = 3,
  parameter int VAL_W     = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [KEY_W-1:0]               req_key,
  input  logic [VAL_W-1:0]               req_value,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic                           rsp_hit,
  output logic [VAL_W-1:0]               rsp_value,
  output logic                           rsp_evict,
  output logic [$clog2(N_ENTRIES+1)-1:0] occupancy
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int OCC_W = $clog2(N_ENTRIES+1);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MATCH, S_UPDATE, S_RESP} state_t;

  state_t r_state, w_next_state;

  logic [KEY_W-1:0]     r_keys [N_ENTRIES];
  logic [VAL_W-1:0]     r_vals [N_ENTRIES];
  logic [N_ENTRIES-1:0] r_valid;
  logic [IDX_W-1:0]     r_rr;

  logic [1:0]           r_op;
  logic [KEY_W-1:0]     r_key;
  logic [VAL_W-1:0]     r_val;
  logic                 r_hit;
  logic                 r_full;
  logic [IDX_W-1:0]     r_hit_idx;
  logic [IDX_W-1:0]     r_free_idx;

  logic                 r_rsp_hit;
  logic [VAL_W-1:0]     r_rsp_value;
  logic                 r_rsp_evict;

  logic                 w_accept;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic [IDX_W-1:0]     w_free_idx;
  logic [OCC_W-1:0]     w_occ;

  logic                 w_wr;
  logic [IDX_W-1:0]     w_wr_idx;
  logic                 w_set_valid;
  logic                 w_clr_valid;
  logic                 w_clr_all;
  logic                 w_rr_adv;
  logic                 w_rsp_hit;
  logic [VAL_W-1:0]     w_rsp_value;
  logic                 w_rsp_evict;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next_state = S_MATCH;
      S_MATCH:  w_next_state = S_UPDATE;
      S_UPDATE: w_next_state = S_RESP;
      S_RESP:   if (rsp_ready) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
  end

  assign w_accept = req_valid && req_ready;

  // Descending scan leaves the lowest matching / lowest free index.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    w_occ      = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_keys[i] == r_key)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
      w_occ = w_occ + OCC_W'(r_valid[i]);
    end
  end

  always_comb begin
    w_wr        = 1'b0;
    w_wr_idx    = r_hit_idx;
    w_set_valid = 1'b0;
    w_clr_valid = 1'b0;
    w_clr_all   = 1'b0;
    w_rr_adv    = 1'b0;
    w_rsp_hit   = 1'b0;
    w_rsp_value = '0;
    w_rsp_evict = 1'b0;
    case (r_op)
      OP_LOOKUP: begin
        w_rsp_hit = r_hit;
        if (r_hit) w_rsp_value = r_vals[r_hit_idx];
      end
      OP_INSERT: begin
        w_wr = 1'b1;
        if (r_hit) begin
          w_rsp_hit   = 1'b1;
          w_rsp_value = r_vals[r_hit_idx];
        end else if (!r_full) begin
          w_wr_idx    = r_free_idx;
          w_set_valid = 1'b1;
        end else begin
          w_wr_idx    = r_rr;
          w_rsp_evict = 1'b1;
          w_rsp_value = r_vals[r_rr];
          w_rr_adv    = 1'b1;
        end
      end
      OP_DELETE: begin
        if (r_hit) begin
          w_clr_valid = 1'b1;
          w_rsp_hit   = 1'b1;
          w_rsp_value = r_vals[r_hit_idx];
        end
      end
      default: w_clr_all = 1'b1;
    endcase
  end

  // Request latch, match results and entry payloads carry no reset; only r_valid qualifies them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op  <= req_op;
      r_key <= req_key;
      r_val <= req_value;
    end
    if (r_state == S_MATCH) begin
      r_hit      <= w_hit;
      r_hit_idx  <= w_hit_idx;
      r_free_idx <= w_free_idx;
      r_full     <= &r_valid;
    end
    if ((r_state == S_UPDATE) && w_wr) begin
      r_keys[w_wr_idx] <= r_key;
      r_vals[w_wr_idx] <= r_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_rr        <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_value <= '0;
      r_rsp_evict <= 1'b0;
    end else if (r_state == S_UPDATE) begin
      r_rsp_hit   <= w_rsp_hit;
      r_rsp_value <= w_rsp_value;
      r_rsp_evict <= w_rsp_evict;
      if (w_clr_all) begin
        r_valid <= '0;
        r_rr    <= '0;
      end else begin
        if (w_set_valid) r_valid[w_wr_idx] <= 1'b1;
        if (w_clr_valid) r_valid[r_hit_idx] <= 1'b0;
        if (w_rr_adv)    r_rr <= r_rr + IDX_W'(1);
      end
    end
  end

  assign rsp_hit   = r_rsp_hit;
  assign rsp_value = r_rsp_value;
  assign rsp_evict = r_rsp_evict;
  assign occupancy = w_occ;

endmodule

// File: tb/tb_ht_controller.sv
// Scoreboard bench for ht_controller: expected responses are queued at issue and popped by a response monitor.
module tb_ht_controller;

  localparam logic [1:0] LOOKUP = 2'b00;
  localparam logic [1:0] INSERT = 2'b01;
  localparam logic [1:0] DELETE = 2'b10;
  localparam logic [1:0] CLEAR  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [2:0] req_key = 3'd0;
  logic [2:0] req_value = 3'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_hit;
  logic [2:0] rsp_value;
  logic       rsp_evict;
  logic [2:0] occupancy;

  typedef struct packed {
    logic       hit;
    logic [2:0] value;
    logic       evict;
    logic [2:0] occ;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  ht_controller #(.N_ENTRIES(4), .KEY_W(3), .VAL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_value(rsp_value), .rsp_evict(rsp_evict), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Response monitor: every accepted response is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_rsp: response seen with hit=%0d value=%0d, none expected", rsp_hit, rsp_value);
      end else begin
        n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (rsp_hit !== e.hit) $display("FAIL rsp_hit: got %0d want %0d", rsp_hit, e.hit);
        else n_pass++;
        n_checks++;
        if (rsp_value !== e.value) $display("FAIL rsp_value: got %0d want %0d", rsp_value, e.value);
        else n_pass++;
        n_checks++;
        if (rsp_evict !== e.evict) $display("FAIL rsp_evict: got %0d want %0d", rsp_evict, e.evict);
        else n_pass++;
        n_checks++;
        if (occupancy !== e.occ) $display("FAIL occupancy: got %0d want %0d", occupancy, e.occ);
        else n_pass++;
      end
    end
  end

  function automatic void expect_rsp(input logic h, input logic [2:0] v, input logic ev, input logic [2:0] o);
    exp_t e;
    e.hit = h; e.value = v; e.evict = ev; e.occ = o;
    sb.push_back(e);
  endfunction

  // Drives one request and waits for its response; lat counts negedges from acceptance to rsp_valid.
  task automatic do_req(input logic [1:0] op, input logic [2:0] key, input logic [2:0] val, output int lat);
    int waited;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_key = key; req_value = val;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      n_checks++;
      $display("FAIL rsp_timeout: rsp_valid still %0d after %0d cycles, want 1", rsp_valid, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({rsp_valid, rsp_hit, rsp_evict} !== 3'b000) $display("FAIL reset_rsp_flags: got %b want 000", {rsp_valid, rsp_hit, rsp_evict});
    else n_pass++;
    n_checks++;
    if (rsp_value !== 3'd0 || occupancy !== 3'd0) $display("FAIL reset_value_occ: got value=%0d occ=%0d want 0/0", rsp_value, occupancy);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0d want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_insert_fill;
    logic [2:0] keys [4];
    logic [2:0] vals [4];
    int lat;
    keys = '{3'd5, 3'd6, 3'd1, 3'd2};
    vals = '{3'd1, 3'd2, 3'd1, 3'd3};
    for (int i = 0; i < 4; i++) begin
      expect_rsp(1'b0, 3'd0, 1'b0, 3'(i + 1));
      do_req(INSERT, keys[i], vals[i], lat);
      n_checks++;
      if (lat !== 3) $display("FAIL insert_latency[%0d]: got %0d cycles want 3", i, lat);
      else n_pass++;
    end
  endtask

  task automatic test_lookup;
    int lat;
    expect_rsp(1'b1, 3'd2, 1'b0, 3'd4); do_req(LOOKUP, 3'd6, 3'd0, lat);
    expect_rsp(1'b1, 3'd3, 1'b0, 3'd4); do_req(LOOKUP, 3'd2, 3'd0, lat);
    expect_rsp(1'b0, 3'd0, 1'b0, 3'd4); do_req(LOOKUP, 3'd7, 3'd5, lat);
    n_checks++;
    if (lat !== 3) $display("FAIL lookup_latency: got %0d cycles want 3", lat);
    else n_pass++;
  endtask

  task automatic test_evict;
    int lat;
    expect_rsp(1'b0, 3'd1, 1'b1, 3'd4); do_req(INSERT, 3'd4, 3'd7, lat);
    expect_rsp(1'b0, 3'd0, 1'b0, 3'd4); do_req(LOOKUP, 3'd5, 3'd0, lat);
    expect_rsp(1'b0, 3'd2, 1'b1, 3'd4); do_req(INSERT, 3'd3, 3'd5, lat);
    expect_rsp(1'b1, 3'd3, 1'b0, 3'd4); do_req(INSERT, 3'd2, 3'd6, lat);
    expect_rsp(1'b1, 3'd6, 1'b0, 3'd4); do_req(LOOKUP, 3'd2, 3'd0, lat);
    expect_rsp(1'b1, 3'd5, 1'b0, 3'd4); do_req(LOOKUP, 3'd3, 3'd0, lat);
  endtask

  task automatic test_delete_clear;
    int lat;
    expect_rsp(1'b1, 3'd1, 1'b0, 3'd3); do_req(DELETE, 3'd1, 3'd0, lat);
    expect_rsp(1'b0, 3'd0, 1'b0, 3'd3); do_req(DELETE, 3'd1, 3'd0, lat);
    expect_rsp(1'b0, 3'd0, 1'b0, 3'd4); do_req(INSERT, 3'd0, 3'd4, lat);
    expect_rsp(1'b1, 3'd4, 1'b0, 3'd4); do_req(LOOKUP, 3'd0, 3'd0, lat);
    expect_rsp(1'b0, 3'd0, 1'b0, 3'd0); do_req(CLEAR, 3'd0, 3'd0, lat);
    expect_rsp(1'b0, 3'd0, 1'b0, 3'd0); do_req(LOOKUP, 3'd4, 3'd0, lat);
    // After CLEAR the round-robin pointer restarts and the table fills from entry 0 again.
    expect_rsp(1'b0, 3'd0, 1'b0, 3'd1); do_req(INSERT, 3'd7, 3'd5, lat);
  endtask

  task automatic test_backpressure;
    int lat;
    logic [5:0] snap;
    logic stable;
    rsp_ready = 1'b0;
    expect_rsp(1'b1, 3'd5, 1'b0, 3'd1);
    do_req(LOOKUP, 3'd7, 3'd0, lat);
    snap = {rsp_valid, rsp_hit, rsp_value, rsp_evict};
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_hit, rsp_value, rsp_evict} !== snap || req_ready !== 1'b0) stable = 1'b0;
    end
    n_checks++;
    if (!stable || snap[5] !== 1'b1) $display("FAIL hold_stable: stable=%0d valid=%0d want 1/1", stable, snap[5]);
    else n_pass++;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL hold_release: req_ready=%0d rsp_valid=%0d want 1/0", req_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_cmd;
    int lat;
    logic quiet;
    expect_rsp(1'b0, 3'd0, 1'b0, 3'd2); do_req(INSERT, 3'd3, 3'd3, lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = INSERT; req_key = 3'd5; req_value = 3'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || occupancy !== 3'd0) $display("FAIL midreset_state: rsp_valid=%0d occ=%0d want 0/0", rsp_valid, occupancy);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL midreset_no_rsp: a response appeared after reset release, want none");
    else n_pass++;
    expect_rsp(1'b0, 3'd0, 1'b0, 3'd0); do_req(LOOKUP, 3'd3, 3'd0, lat);
    expect_rsp(1'b0, 3'd0, 1'b0, 3'd0); do_req(LOOKUP, 3'd5, 3'd0, lat);
  endtask

  initial begin
    test_reset();
    test_insert_fill();
    test_lookup();
    test_evict();
    test_delete_clear();
    test_backpressure();
    test_reset_mid_cmd();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d expected responses never seen, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
